qspi_psram_responder: RTL

Synthesizable QSPI target that emulates the PSRAM side of our flash/PSRAM controller link, for FPGA bring-up and closed-loop simulation. It accepts 35h (enter quad, single-bit), then quad-mode 0Bh (read) and 02h (write) transactions, translating them to a byte-wide memory port. All SPI pins are oversampled in the local `clk` domain; no logic is clocked by SCLK.

---
 rtl/qspi_psram_responder_if.sv | 28 ++
 rtl/qspi_psram_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_psram_responder_if.sv
// QSPI pin bundle plus the byte-wide memory port served by the PSRAM responder.
interface qspi_psram_responder_if #(
  parameter int unsigned ADDR_BITS = 24
);
  logic                 spi_clk_in;
  logic                 spi_cs_n;
  logic [3:0]           spi_data_in;
  logic [3:0]           spi_data_out;
  logic [3:0]           spi_data_oe;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_re;
  logic [7:0]           mem_rdata;
  logic                 mem_we;
  logic [7:0]           mem_wdata;
  logic                 quad_mode;

  // Initiator plus backing memory side.
  modport master (
    output spi_clk_in, spi_cs_n, spi_data_in, mem_rdata,
    input  spi_data_out, spi_data_oe, mem_addr, mem_re, mem_we, mem_wdata, quad_mode
  );

  // Responder side.
  modport slave (
    input  spi_clk_in, spi_cs_n, spi_data_in, mem_rdata,
    output spi_data_out, spi_data_oe, mem_addr, mem_re, mem_we, mem_wdata, quad_mode
  );
endinterface

// File: rtl/qspi_psram_responder.sv
// QSPI PSRAM responder: oversamples the SPI pins in the clk domain, decodes
// 35h / F5h / 0Bh / 02h and maps reads/writes onto a byte-wide memory port.
module qspi_psram_responder #(
  parameter int unsigned ADDR_BITS    = 24,
  parameter int unsigned DUMMY_CYCLES = 4
) (
  input logic                   clk,
  input logic                   rstn,
  qspi_psram_responder_if.slave bus
);
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned ADDR_NIBBLES = ADDR_BITS / 4;
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_NIBBLES - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'((DUMMY_CYCLES > 0) ? DUMMY_CYCLES - 1 : 0);
  localparam logic [7:0] CMD_ENTER_QUAD = 8'h35;
  localparam logic [7:0] CMD_EXIT_QUAD  = 8'hF5;
  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [7:0] CMD_WRITE      = 8'h02;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE
  } state_t;

  logic [1:0] sclk_sync;
  logic [1:0] cs_sync;
  logic [3:0] data_sync0, data_sync1;
  logic       sclk_prev;
  logic       sclk_rise, sclk_fall, cs_high;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [6:0]           cmd_sr, cmd_sr_n;
  logic [ADDR_BITS-1:0] addr, addr_n;
  logic                 is_read, is_read_n;
  logic                 hi_next, hi_next_n;
  logic [3:0]           wr_hi, wr_hi_n;
  logic [7:0]           rd_byte, rd_byte_n;
  logic                 re_dly;
  logic                 quad, quad_n;
  logic [3:0]           dout, dout_n;
  logic [3:0]           oe, oe_n;
  logic [ADDR_BITS-1:0] maddr, maddr_n;
  logic                 re, re_n;
  logic                 we, we_n;
  logic [7:0]           wdata, wdata_n;

  logic [7:0]           cmd_single, cmd_quad;
  logic [ADDR_BITS-1:0] addr_shift, addr_inc;

  // Two-flop synchronizers and SCLK edge history.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_sync  <= 2'b00;
      cs_sync    <= 2'b11;
      data_sync0 <= 4'h0;
      data_sync1 <= 4'h0;
      sclk_prev  <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[0], bus.spi_clk_in};
      cs_sync    <= {cs_sync[0], bus.spi_cs_n};
      data_sync0 <= bus.spi_data_in;
      data_sync1 <= data_sync0;
      sclk_prev  <= sclk_sync[1];
    end
  end

  assign sclk_rise  = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall  = ~sclk_sync[1] & sclk_prev;
  assign cs_high    = cs_sync[1];
  assign cmd_single = {cmd_sr, data_sync1[0]};
  assign cmd_quad   = {cmd_sr[3:0], data_sync1};
  assign addr_shift = {addr[ADDR_BITS-5:0], data_sync1};
  assign addr_inc   = addr + ADDR_BITS'(1);

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      cmd_sr  <= '0;
      addr    <= '0;
      is_read <= 1'b0;
      hi_next <= 1'b1;
      wr_hi   <= 4'h0;
      rd_byte <= 8'h00;
      re_dly  <= 1'b0;
      quad    <= 1'b0;
      dout    <= 4'h0;
      oe      <= 4'h0;
      maddr   <= '0;
      re      <= 1'b0;
      we      <= 1'b0;
      wdata   <= 8'h00;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      cmd_sr  <= cmd_sr_n;
      addr    <= addr_n;
      is_read <= is_read_n;
      hi_next <= hi_next_n;
      wr_hi   <= wr_hi_n;
      rd_byte <= rd_byte_n;
      re_dly  <= re;
      quad    <= quad_n;
      dout    <= dout_n;
      oe      <= oe_n;
      maddr   <= maddr_n;
      re      <= re_n;
      we      <= we_n;
      wdata   <= wdata_n;
    end
  end

  // Next-state and next-output decode; CS high overrides everything.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    cmd_sr_n  = cmd_sr;
    addr_n    = addr;
    is_read_n = is_read;
    hi_next_n = hi_next;
    wr_hi_n   = wr_hi;
    rd_byte_n = re_dly ? bus.mem_rdata : rd_byte;
    quad_n    = quad;
    dout_n    = dout;
    maddr_n   = maddr;
    re_n      = 1'b0;
    we_n      = 1'b0;
    wdata_n   = wdata;

    if (cs_high) begin
      state_n   = IDLE;
      cnt_n     = '0;
      hi_next_n = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          state_n   = CMD;
          cnt_n     = '0;
          hi_next_n = 1'b1;
        end
        CMD: if (sclk_rise) begin
          cnt_n = cnt + CNT_W'(1);
          if (!quad) begin
            cmd_sr_n = cmd_single[6:0];
            if (cnt == CNT_W'(7)) begin
              state_n = IGNORE;
              if (cmd_single == CMD_ENTER_QUAD) quad_n = 1'b1;
            end
          end else begin
            cmd_sr_n = {3'b000, cmd_quad[3:0]};
            if (cnt == CNT_W'(1)) begin
              cnt_n = '0;
              case (cmd_quad)
                CMD_READ: begin
                  is_read_n = 1'b1;
                  state_n   = ADDR;
                end
                CMD_WRITE: begin
                  is_read_n = 1'b0;
                  state_n   = ADDR;
                end
                CMD_EXIT_QUAD: begin
                  quad_n  = 1'b0;
                  state_n = IGNORE;
                end
                default: state_n = IGNORE;
              endcase
            end
          end
        end
        ADDR: if (sclk_rise) begin
          addr_n = addr_shift;
          cnt_n  = cnt + CNT_W'(1);
          if (cnt == ADDR_LAST) begin
            cnt_n     = '0;
            hi_next_n = 1'b1;
            if (is_read) begin
              re_n    = 1'b1;
              maddr_n = addr_shift;
              state_n = (DUMMY_CYCLES == 0) ? RDATA : DUMMY;
            end else begin
              state_n = WDATA;
            end
          end
        end
        DUMMY: if (sclk_rise) begin
          cnt_n = cnt + CNT_W'(1);
          if (cnt == DUMMY_LAST) begin
            cnt_n   = '0;
            state_n = RDATA;
          end
        end
        RDATA: if (sclk_fall) begin
          if (hi_next) begin
            dout_n    = rd_byte[7:4];
            hi_next_n = 1'b0;
          end else begin
            // Low nibble goes out: prefetch the following byte now.
            dout_n    = rd_byte[3:0];
            hi_next_n = 1'b1;
            addr_n    = addr_inc;
            maddr_n   = addr_inc;
            re_n      = 1'b1;
          end
        end
        WDATA: if (sclk_rise) begin
          if (hi_next) begin
            wr_hi_n   = data_sync1;
            hi_next_n = 1'b0;
          end else begin
            we_n      = 1'b1;
            wdata_n   = {wr_hi, data_sync1};
            maddr_n   = addr;
            addr_n    = addr_inc;
            hi_next_n = 1'b1;
          end
        end
        IGNORE: ;
        default: state_n = IDLE;
      endcase
    end

    oe_n = (state_n == RDATA) ? 4'hF : 4'h0;
  end

  assign bus.spi_data_out = dout;
  assign bus.spi_data_oe  = oe;
  assign bus.mem_addr     = maddr;
  assign bus.mem_re       = re;
  assign bus.mem_we       = we;
  assign bus.mem_wdata    = wdata;
  assign bus.quad_mode    = quad;
endmodule
